// File: rtl/vsync_generator_if.sv
// rtl/vsync_generator_if.sv - line pulse input and vertical timing outputs of the vsync generator
interface vsync_generator_if;
    logic       line_done;
    logic       vsync;
    logic [6:0] vpixel;
    logic       en;
    logic       frame_start;

    // Generator side: consumes line pulses, produces vertical timing
    modport master (
        input  line_done,
        output vsync,
        output vpixel,
        output en,
        output frame_start
    );

    // Consumer side: supplies line pulses, observes vertical timing
    modport slave (
        output line_done,
        input  vsync,
        input  vpixel,
        input  en,
        input  frame_start
    );
endinterface

// File: rtl/vsync_generator.sv
// rtl/vsync_generator.sv - vertical sync / display-enable / logical row generator driven by line pulses
module vsync_generator #(
    parameter int SYNC_LINES = 2,
    parameter int BP_LINES   = 29,
    parameter int DISP_LINES = 480,
    parameter int FP_LINES   = 10,
    parameter int ROW_REPEAT = 5
) (
    input  logic              clk,
    input  logic              reset,
    vsync_generator_if.master bus
);
    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        BP      = 2'd1,
        DISPLAY = 2'd2,
        FP      = 2'd3
    } state_t;

    // Line counter must hold the longest phase length minus one
    localparam int MAX_AB  = (SYNC_LINES > BP_LINES) ? SYNC_LINES : BP_LINES;
    localparam int MAX_CD  = (DISP_LINES > FP_LINES) ? DISP_LINES : FP_LINES;
    localparam int MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int REP_W   = $clog2(ROW_REPEAT + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LINES - 1);
    localparam logic [CNT_W-1:0] BP_LAST   = CNT_W'(BP_LINES - 1);
    localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISP_LINES - 1);
    localparam logic [CNT_W-1:0] FP_LAST   = CNT_W'(FP_LINES - 1);
    localparam logic [REP_W-1:0] REP_LAST  = REP_W'(ROW_REPEAT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] last_idx;
    logic [REP_W-1:0] rep, rep_nxt;
    logic [6:0]       row, row_nxt;
    logic             phase_end;

    // Index of the final line of the current phase
    always_comb begin
        last_idx = SYNC_LAST;
        case (state)
            SYNC:    last_idx = SYNC_LAST;
            BP:      last_idx = BP_LAST;
            DISPLAY: last_idx = DISP_LAST;
            FP:      last_idx = FP_LAST;
            default: last_idx = SYNC_LAST;
        endcase
    end

    assign phase_end = bus.line_done && (cnt == last_idx);

    // Next-state, line counter and row/repeat counters; everything holds without line_done
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rep_nxt   = rep;
        row_nxt   = row;
        if (bus.line_done) begin
            if (phase_end) begin
                cnt_nxt = '0;
                case (state)
                    SYNC:    state_nxt = BP;
                    BP:      state_nxt = DISPLAY;
                    DISPLAY: state_nxt = FP;
                    FP:      state_nxt = SYNC;
                    default: state_nxt = SYNC;
                endcase
            end else begin
                cnt_nxt = cnt + 1'b1;
            end

            // Row stepping only happens in DISPLAY; leaving DISPLAY clears it so
            // the row index never reaches DISP_LINES/ROW_REPEAT
            if (state == DISPLAY) begin
                if (phase_end) begin
                    rep_nxt = '0;
                    row_nxt = '0;
                end else if (rep == REP_LAST) begin
                    rep_nxt = '0;
                    row_nxt = row + 7'd1;
                end else begin
                    rep_nxt = rep + 1'b1;
                end
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SYNC;
            cnt   <= '0;
            rep   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rep   <= rep_nxt;
            row   <= row_nxt;
        end
    end

    // Registered outputs decoded from the next state so they change together with it
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.vsync       <= 1'b0;
            bus.en          <= 1'b0;
            bus.vpixel      <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.vsync       <= (state_nxt != SYNC);
            bus.en          <= (state_nxt == DISPLAY);
            bus.vpixel      <= row_nxt;
            bus.frame_start <= phase_end && (state == FP);
        end
    end
endmodule

// File: tb/tb_vsync_generator.sv
// tb/tb_vsync_generator.sv - randomized self-checking bench for vsync_generator
module tb_vsync_generator;
    localparam int SYNC_L = 2;
    localparam int BP_L   = 29;
    localparam int DISP_L = 480;
    localparam int FP_L   = 10;
    localparam int RR     = 5;
    localparam int FRAME  = SYNC_L + BP_L + DISP_L + FP_L;

    logic clk;
    logic reset;
    vsync_generator_if bus();

    vsync_generator #(
        .SYNC_LINES(SYNC_L),
        .BP_LINES  (BP_L),
        .DISP_LINES(DISP_L),
        .FP_LINES  (FP_L),
        .ROW_REPEAT(RR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    logic fs_exp = 1'b0;
    int fs_seen = 0;
    int en_cycles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d pulses=%0d", tag, obs, exp, pulses);
        end
    endtask

    // Expected outputs from the number of line pulses counted since reset
    task automatic check_all();
        int l;
        logic v_e, en_e;
        int row_e;
        l     = pulses % FRAME;
        v_e   = (l >= SYNC_L);
        en_e  = (l >= SYNC_L + BP_L) && (l < SYNC_L + BP_L + DISP_L);
        row_e = en_e ? (l - SYNC_L - BP_L) / RR : 0;
        check("vsync", 32'(bus.vsync), 32'(v_e));
        check("en", 32'(bus.en), 32'(en_e));
        check("vpixel", 32'(bus.vpixel), 32'(row_e));
        check("frame_start", 32'(bus.frame_start), 32'(fs_exp));
    endtask

    task automatic cycle(input logic ld, input logic rs);
        bus.line_done = ld;
        reset = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            pulses = 0;
            fs_exp = 1'b0;
        end else if (ld) begin
            pulses++;
            fs_exp = ((pulses % FRAME) == 0);
        end else begin
            fs_exp = 1'b0;
        end
        if (bus.frame_start === 1'b1) fs_seen++;
        if (bus.en === 1'b1) en_cycles++;
        check_all();
    endtask

    task automatic pulse_gapped(input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
        end
    endtask

    initial begin
        bus.line_done = 1'b0;
        reset = 1'b1;

        // Reset held with no line pulses
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);

        // Two full frames with random gaps between pulses
        fs_seen = 0;
        pulse_gapped(2 * FRAME);
        check("frame_start_count_gapped", 32'(fs_seen), 32'd2);

        // Back-to-back pulses: whole frames at one line per cycle
        fs_seen = 0;
        en_cycles = 0;
        for (int i = 0; i < 2 * FRAME; i++) cycle(1'b1, 1'b0);
        check("frame_start_count_b2b", 32'(fs_seen), 32'd2);
        check("en_cycles_b2b", 32'(en_cycles), 32'(2 * DISP_L));

        // Reset coincident with a pulse mid-DISPLAY
        cycle(1'b0, 1'b1);
        pulse_gapped(199);
        cycle(1'b1, 1'b1);
        check("reset_mid_display_en", 32'(bus.en), 32'd0);
        check("reset_mid_display_vsync", 32'(bus.vsync), 32'd0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("vsync_after_two", 32'(bus.vsync), 32'd1);

        // Long idle from inside DISPLAY: nothing may change
        pulse_gapped(100);
        for (int i = 0; i < 1000; i++) cycle(1'b0, 1'b0);

        // Random pulses with occasional resets
        for (int i = 0; i < 4000; i++) begin
            logic ld, rs;
            ld = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 699) == 0);
            cycle(ld, rs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vsync_generator.md
VSYNC_GENERATOR -- requirements
Module: vsync_generator

Interface
Parameters (name, default, meaning):
REQ-001 SYNC_LINES, 2, lines with vsync asserted.
REQ-002 BP_LINES, 29, vertical back-porch lines.
REQ-003 DISP_LINES, 480, visible lines.
REQ-004 FP_LINES, 10, vertical front-porch lines.
REQ-005 ROW_REPEAT, 5, physical lines per logical row; legal only if it divides DISP_LINES, DISP_LINES/ROW_REPEAT <= 128, and every parameter >= 1.

Ports (name, direction, width, meaning):
REQ-006 clk, in, 1, single clock (50 MHz nominal); all logic on rising edge.
REQ-007 reset, in, 1, synchronous, active-high; driven from the synchronizer output.
REQ-008 line_done, in, 1, one-cycle end-of-line pulse from hsync_generator.
REQ-009 vsync, out, 1, vertical sync, active-low.
REQ-010 vpixel, out, 7, logical row index 0..DISP_LINES/ROW_REPEAT-1.
REQ-011 en, out, 1, vertical display enable; high only in DISPLAY.
REQ-012 frame_start, out, 1, one-cycle pulse at start of each new frame.

Function
REQ-013 Four-state FSM SHALL be used: SYNC -> BP -> DISPLAY -> FP -> SYNC.
REQ-014 State occupancy SHALL be SYNC_LINES, BP_LINES, DISP_LINES and FP_LINES line_done pulses respectively; frame = 521 pulses at defaults.
REQ-015 Line counter: on line_done, if count == current state length - 1 -> next state, count = 0; else count + 1.
REQ-016 Without line_done, state and all counters SHALL hold; line_done is the only advance event.
REQ-017 All outputs SHALL be registered; latency is 1 cycle from the sampled line_done edge to the output change.
REQ-018 vsync SHALL be 0 in SYNC and 1 in all other states.
REQ-019 en SHALL be 1 in DISPLAY and 0 otherwise.
REQ-020 Repeat counter rep (0..ROW_REPEAT-1), active only in DISPLAY: on line_done, if rep == ROW_REPEAT-1 -> rep = 0, vpixel + 1; else rep + 1.
REQ-021 On the DISPLAY -> FP transition, vpixel and rep SHALL clear to 0; vpixel never exceeds DISP_LINES/ROW_REPEAT-1 (95 at defaults) and never wraps within DISPLAY.
REQ-022 vpixel SHALL be 0 in SYNC, BP and FP.
REQ-023 frame_start SHALL pulse high for exactly one cycle, the cycle after the line_done that causes FP -> SYNC; it SHALL be 0 otherwise, including after reset.
REQ-024 Back-to-back line_done (high every cycle) SHALL advance one line per cycle with no lost or duplicated pulses.
REQ-025 Counter widths SHALL hold DISP_LINES-1 without overflow.

Reset
REQ-026 While reset = 1 at a clock edge: state = SYNC, line count = 0, rep = 0, vsync = 0, vpixel = 0, en = 0, frame_start = 0.
REQ-027 Reset SHALL take priority over a coincident line_done; that pulse is discarded.
REQ-028 Reset asserted mid-frame (any state) SHALL abort the frame; counting restarts from SYNC line 0 on the first line_done after reset deasserts.

Verification
REQ-029 Reset held 10 cycles, line_done = 0 -> vsync = 0, en = 0, vpixel = 0, frame_start = 0 throughout and after release.
REQ-030 After reset, 2 line_done pulses -> vsync = 1 one cycle after the 2nd pulse; 31 pulses -> en = 1, vpixel = 0; 36 pulses -> vpixel = 1; 506 pulses -> vpixel = 95; 511 pulses -> en = 0, vpixel = 0.
REQ-031 521 pulses -> vsync = 0 and frame_start = 1 for exactly one cycle; the next 521 pulses repeat the identical sequence.
REQ-032 line_done held high continuously -> frame_start pulses exactly every 521 cycles; en high for exactly 480 consecutive cycles per frame.
REQ-033 Reset asserted after 200 pulses (mid-DISPLAY), coincident with a line_done -> next cycle en = 0, vpixel = 0, vsync = 0; 2 further pulses after release -> vsync = 1.
REQ-034 line_done = 0 for 1000 cycles from any state -> no output change.
